// File: rtl/shifter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : shifter_pkg
//  Purpose  : Shared types for the pipelined barrel shifter (EXU shift unit).
//             Defines the shift operation encoding used on the in_op port and
//             carried through every pipeline stage.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package shifter_pkg;

  // Operation encoding: 00 SLL, 01 SRL, 10 SRA, 11 ROR
  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } shift_op_t;

endpackage : shifter_pkg
`default_nettype wire

// File: rtl/shift_stage.sv
`default_nettype none
// ============================================================================
//  Module   : shift_stage
//  Purpose  : One level of the pipelined barrel shifter. Conditionally shifts
//             the incoming operand by 2^K (when shamt bit K is set) and
//             registers the result together with op, shamt, sign and tag.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             valid_i, op_i,
//             data_i, shamt_i,
//             sign_i, tag_i     - upstream stage contents
//             ready_i           - downstream stage can accept
//             valid_o, op_o,
//             data_o, shamt_o,
//             sign_o, tag_o     - this stage's register contents
//  Revision : 1.0 - initial release
// ============================================================================
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  parameter int SHW   = 5,
  parameter int K     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  shift_op_t        op_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [SHW-1:0]   shamt_i,
  input  logic             sign_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             ready_i,
  output logic             valid_o,
  output shift_op_t        op_o,
  output logic [WIDTH-1:0] data_o,
  output logic [SHW-1:0]   shamt_o,
  output logic             sign_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int S   = 1 << K;      // shift distance of this level
  localparam int SHL = WIDTH - S;   // complementary distance for fill/rotate

  logic             valid_q;
  shift_op_t        op_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic [SHW-1:0]   shamt_q;
  logic             sign_q;
  logic [TAG_W-1:0] tag_q;
  logic             advance;

  // The register may load whenever it is empty or its content moves on.
  assign advance = ~valid_q | ready_i;

  always_comb begin
    data_d = data_i;
    if (shamt_i[K]) begin
      case (op_i)
        OP_SLL:  data_d = data_i << S;
        OP_SRL:  data_d = data_i >> S;
        // Fill comes from the sign captured at the pipe input, not from the
        // partially shifted operand, whose MSB may already be a fill bit.
        OP_SRA:  data_d = (data_i >> S) | ({WIDTH{sign_i}} << SHL);
        OP_ROR:  data_d = (data_i >> S) | (data_i << SHL);
        default: data_d = data_i;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      op_q    <= OP_SLL;
      data_q  <= '0;
      shamt_q <= '0;
      sign_q  <= 1'b0;
      tag_q   <= '0;
    end else if (advance) begin
      valid_q <= valid_i;
      if (valid_i) begin
        op_q    <= op_i;
        data_q  <= data_d;
        shamt_q <= shamt_i;
        sign_q  <= sign_i;
        tag_q   <= tag_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign op_o    = op_q;
  assign data_o  = data_q;
  assign shamt_o = shamt_q;
  assign sign_o  = sign_q;
  assign tag_o   = tag_q;

endmodule : shift_stage
`default_nettype wire

// File: rtl/pipe_barrel_shifter.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_barrel_shifter
//  Purpose  : Pipelined SLL/SRL/SRA/ROR barrel shifter, one register per
//             log2(WIDTH) mux level, elastic valid/ready with per-stage
//             backpressure and a sideband tag travelling with each op.
//  Ports    : clk, rst                      - clock, sync active-high reset
//             in_valid, in_ready            - input handshake
//             in_op, in_data, in_shamt,
//             in_tag                        - operation, operand, amount, tag
//             out_valid, out_ready          - output handshake
//             out_data, out_tag             - result and its tag
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_barrel_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  shift_op_t        in_op,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  generate
    if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : g_width_check
      $error("pipe_barrel_shifter: WIDTH must be a power of two and >= 4");
    end
  endgenerate

  // Index 0 is the pipe input; index k+1 is the register of stage k.
  logic             valid_s [SHW+1];
  shift_op_t        op_s    [SHW+1];
  logic [WIDTH-1:0] data_s  [SHW+1];
  logic [SHW-1:0]   shamt_s [SHW+1];
  logic             sign_s  [SHW+1];
  logic [TAG_W-1:0] tag_s   [SHW+1];

  logic [SHW-1:0]   valid_vec;  // valid bit of every stage register
  logic [SHW:0]     ready_s;    // ready_s[k]: stage k can load this cycle

  assign valid_s[0] = in_valid;
  assign op_s[0]    = in_op;
  assign data_s[0]  = in_data;
  assign shamt_s[0] = in_shamt;
  assign sign_s[0]  = in_data[WIDTH-1];
  assign tag_s[0]   = in_tag;

  assign ready_s[SHW] = out_ready;

  generate
    for (genvar k = 0; k < SHW; k++) begin : g_stage
      assign valid_vec[k] = valid_s[k+1];

      // Unrolled form of ready_k = ~valid_k | ready_{k+1}: a stage can load
      // unless it and every stage downstream of it are full and the consumer
      // is stalled. Written this way the ready chain has no self-reference.
      assign ready_s[k] = out_ready | ~(&valid_vec[SHW-1:k]);

      shift_stage #(
        .WIDTH (WIDTH),
        .TAG_W (TAG_W),
        .SHW   (SHW),
        .K     (k)
      ) u_stage (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid_s[k]),
        .op_i    (op_s[k]),
        .data_i  (data_s[k]),
        .shamt_i (shamt_s[k]),
        .sign_i  (sign_s[k]),
        .tag_i   (tag_s[k]),
        .ready_i (ready_s[k+1]),
        .valid_o (valid_s[k+1]),
        .op_o    (op_s[k+1]),
        .data_o  (data_s[k+1]),
        .shamt_o (shamt_s[k+1]),
        .sign_o  (sign_s[k+1]),
        .tag_o   (tag_s[k+1])
      );
    end
  endgenerate

  // Held low during reset so no op is accepted into a pipe being cleared.
  assign in_ready  = ~rst & ready_s[0];

  assign out_valid = valid_s[SHW];
  assign out_data  = data_s[SHW];
  assign out_tag   = tag_s[SHW];

endmodule : pipe_barrel_shifter
`default_nettype wire

// File: tb/tb_pipe_barrel_shifter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_barrel_shifter
//  Purpose  : Self-checking bench for pipe_barrel_shifter (WIDTH=32, TAG_W=4).
//             Expected results are queued on acceptance and compared in
//             order as the DUT delivers them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_barrel_shifter;
  import shifter_pkg::*;

  localparam int WIDTH = 32;
  localparam int TAG_W = 4;
  localparam int SHW   = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  shift_op_t        in_op = OP_SLL;
  logic [WIDTH-1:0] in_data = '0;
  logic [SHW-1:0]   in_shamt = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;

  pipe_barrel_shifter #(
    .WIDTH (WIDTH),
    .TAG_W (TAG_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  t;
    logic [31:0] c;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   n_out = 0;
  int   last_out_cyc = 0;
  int   gap_base = 0;
  bit   lat_chk = 1'b0;
  bit   gap_chk = 1'b0;
  bit   rnd_rdy = 1'b0;
  logic rdy_set = 1'b1;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d,
                                            input logic [4:0] s);
    logic signed [31:0] sd;
    logic [63:0]        dd;
    sd = d;
    dd = {d, d} >> s;
    case (op)
      2'd0:    return d << s;
      2'd1:    return d >> s;
      2'd2:    return sd >>> s;
      default: return dd[31:0];
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer-side ready: random in the stress phase, otherwise rdy_set.
  always @(posedge clk) begin
    #1;
    out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy_set;
  end

  // Output monitor / scoreboard pop.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out", 64'(out_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        check("out_data", 64'(out_data), 64'(e.d));
        check("out_tag", 64'(out_tag), 64'(e.t));
        if (lat_chk) check("latency", 64'(cyc - int'(e.c)), 64'd5);
        if (gap_chk && n_out > gap_base) check("b2b_gap", 64'(cyc - last_out_cyc), 64'd1);
      end
      n_out++;
      last_out_cyc = cyc;
    end
  end

  // Present one op and hold it until accepted; expected result queued then.
  task automatic send(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh,
                      input logic [3:0] tg, input logic [31:0] ex);
    bit acc;
    int n;
    in_valid = 1'b1;
    in_op    = shift_op_t'(op);
    in_data  = d;
    in_shamt = sh;
    in_tag   = tg;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 1000) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        sb.push_back(exp_t'{ex, tg, 32'(cyc)});
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("send_timeout", 64'(acc), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic [1:0]  op;
    logic [31:0] d;
    logic [4:0]  sh;
    logic [3:0]  tg;
    op = 2'($urandom_range(0, 3));
    d  = $urandom;
    sh = 5'($urandom_range(0, 31));
    tg = 4'($urandom_range(0, 15));
    send(op, d, sh, tg, ref_shift(op, d, sh));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int base;
    logic [31:0] d;
    logic [4:0]  sh;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // 1: single SLL, latency 5
    lat_chk = 1'b1;
    send(2'd0, 32'h0000_00F1, 5'd4, 4'd3, 32'h0000_0F10);
    drain();

    // 2: boundary amounts and shamt = 0 for every op
    send(2'd2, 32'h8000_0000, 5'd31, 4'd1, 32'hFFFF_FFFF);
    send(2'd1, 32'h8000_0000, 5'd31, 4'd2, 32'h0000_0001);
    send(2'd3, 32'h0000_0001, 5'd1,  4'd4, 32'h8000_0000);
    send(2'd0, 32'h0000_0001, 5'd31, 4'd6, 32'h8000_0000);
    send(2'd2, 32'h7FFF_FFFF, 5'd31, 4'd7, 32'h0000_0000);
    for (int k = 0; k < 4; k++) send(2'(k), 32'hA5A5_0F0F, 5'd0, 4'(8 + k), 32'hA5A5_0F0F);
    drain();

    // 3: eight back-to-back ops, tags 0..7, consecutive results
    gap_base = n_out;
    gap_chk  = 1'b1;
    base     = n_out;
    for (int i = 0; i < 8; i++) begin
      d  = $urandom;
      sh = 5'($urandom_range(0, 31));
      send(2'(i % 4), d, sh, 4'(i), ref_shift(2'(i % 4), d, sh));
    end
    drain();
    check("b2b_count", 64'(n_out - base), 64'd8);
    gap_chk = 1'b0;
    lat_chk = 1'b0;

    // 4: fill with out_ready low, blocked input, release
    rdy_set = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    base = n_out;
    for (int i = 0; i < 5; i++) send(2'd1, 32'hF000_0000 >> i, 5'(i), 4'(i), (32'hF000_0000 >> i) >> i);
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    in_tag   = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_in_ready", 64'(in_ready), 64'd0);
    end
    check("full_no_output", 64'(n_out - base), 64'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    rdy_set = 1'b1;
    drain();
    check("full_release_count", 64'(n_out - base), 64'd5);

    // 5: random ops with random backpressure
    rnd_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send_rand();
    end
    rnd_rdy = 1'b0;
    drain();

    // 6: reset with three ops in flight
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) send_rand();
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_release_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("midrst_no_stale", 64'(out_valid), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, observed incomplete run expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_pipe_barrel_shifter
`default_nettype wire
